// File: rtl/nn_pkg.sv
// Shared defaults, layer-buffer state type and activation saturation for the
// Connect4 network datapath.
package nn_pkg;

    localparam int unsigned FRAC_BITS = 5;
    localparam int unsigned ACT_WIDTH = 8;
    localparam int unsigned SUM_WIDTH = 11;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } act_state_t;

    // Clamp a signed value into the range of a w-bit two's-complement word.
    function automatic logic signed [31:0] sat_act(input logic signed [31:0] t,
                                                   input int unsigned      w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (t > hi) begin
            return hi;
        end
        if (t < lo) begin
            return lo;
        end
        return t;
    endfunction

endpackage

// File: rtl/act_quant.sv
// Combinational quantizer: sum + bias, optional ReLU, saturate to an activation.
module act_quant #(
    parameter int unsigned SUM_WIDTH = nn_pkg::SUM_WIDTH,
    parameter int unsigned ACT_WIDTH = nn_pkg::ACT_WIDTH,
    parameter int unsigned USE_RELU  = 1
) (
    input  logic signed [SUM_WIDTH-1:0] sum_in,
    input  logic signed [ACT_WIDTH-1:0] bias_in,
    output logic signed [ACT_WIDTH-1:0] act_c
);

    localparam int unsigned TW = SUM_WIDTH + 1;

    logic signed [TW-1:0] t;
    logic signed [31:0]   t_relu;

    // One guard bit above the sum width keeps the add exact.
    always_comb begin
        t      = TW'(sum_in) + TW'(bias_in);
        t_relu = 32'(t);
        if ((USE_RELU != 0) && t[TW-1]) begin
            t_relu = '0;
        end
        act_c = ACT_WIDTH'(nn_pkg::sat_act(t_relu, ACT_WIDTH));
    end

endmodule

// File: rtl/activation_buffer.sv
// Quantizes one layer of neuron sums into a buffer, tracks the argmax, then
// streams the activations out in index order for the next layer.
module activation_buffer #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned SUM_WIDTH   = nn_pkg::SUM_WIDTH,
    parameter int unsigned ACT_WIDTH   = nn_pkg::ACT_WIDTH,
    parameter int unsigned FRAC_BITS   = nn_pkg::FRAC_BITS,
    parameter int unsigned USE_RELU    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sum_valid,
    output logic                                 sum_ready,
    input  logic signed [SUM_WIDTH-1:0]          sum_in,
    input  logic signed [ACT_WIDTH-1:0]          bias_in,
    output logic                                 act_valid,
    input  logic                                 act_ready,
    output logic signed [ACT_WIDTH-1:0]          act_out,
    output logic                                 act_last,
    output logic                                 layer_done,
    output logic [$clog2(NUM_NEURONS)-1:0]       argmax_idx,
    output logic                                 argmax_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    if ((FRAC_BITS >= ACT_WIDTH) || (NUM_NEURONS < 2)) begin : g_param_check
        $error("activation_buffer: unsupported FRAC_BITS/NUM_NEURONS");
    end

    nn_pkg::act_state_t          state;
    nn_pkg::act_state_t          state_nxt;
    logic [IDX_W-1:0]            wr_idx;
    logic [IDX_W-1:0]            rd_idx;
    logic signed [ACT_WIDTH-1:0] act_mem [NUM_NEURONS];
    logic signed [ACT_WIDTH-1:0] max_val;
    logic signed [ACT_WIDTH-1:0] act_c;
    logic                        sum_xfer_c;
    logic                        act_xfer_c;
    logic                        wr_last_c;
    logic                        rd_last_c;

    act_quant #(
        .SUM_WIDTH (SUM_WIDTH),
        .ACT_WIDTH (ACT_WIDTH),
        .USE_RELU  (USE_RELU)
    ) u_quant (
        .sum_in  (sum_in),
        .bias_in (bias_in),
        .act_c   (act_c)
    );

    // Handshake decode straight off the state register.
    assign sum_ready    = (state == nn_pkg::FILL);
    assign act_valid    = (state == nn_pkg::DRAIN);
    assign argmax_valid = act_valid;
    assign sum_xfer_c   = sum_valid && sum_ready;
    assign act_xfer_c   = act_ready && act_valid;
    assign wr_last_c    = (wr_idx == LAST_IDX);
    assign rd_last_c    = (rd_idx == LAST_IDX);
    assign act_out      = act_valid ? act_mem[rd_idx] : '0;
    assign act_last     = act_valid && rd_last_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= nn_pkg::FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            nn_pkg::FILL: begin
                if (sum_xfer_c && wr_last_c) begin
                    state_nxt = nn_pkg::DRAIN;
                end
            end
            nn_pkg::DRAIN: begin
                if (act_xfer_c && rd_last_c) begin
                    state_nxt = nn_pkg::FILL;
                end
            end
            default: state_nxt = nn_pkg::FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= act_xfer_c && rd_last_c;
            if (sum_xfer_c) begin
                wr_idx <= wr_last_c ? '0 : wr_idx + IDX_W'(1);
            end
            if (act_xfer_c) begin
                rd_idx <= rd_last_c ? '0 : rd_idx + IDX_W'(1);
            end
        end
    end

    // Buffer is deliberately not reset; it is masked outside DRAIN.
    always_ff @(posedge clk) begin
        if (sum_xfer_c) begin
            act_mem[wr_idx] <= act_c;
        end
    end

    // Strictly-greater update so ties keep the lowest index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            argmax_idx <= '0;
            max_val    <= '0;
        end else if (sum_xfer_c && ((wr_idx == '0) || (act_c > max_val))) begin
            argmax_idx <= wr_idx;
            max_val    <= act_c;
        end
    end

endmodule

// File: tb/tb_activation_buffer.sv
// Self-checking bench: two buffers (ReLU and linear) share one stimulus stream
// and are compared every cycle against a queue-level reference model.
module tb_activation_buffer;

    localparam int unsigned NN = 4;
    localparam int unsigned SW = 11;
    localparam int unsigned AW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sum_valid;
    logic                 act_ready;
    logic signed [SW-1:0] sum_in;
    logic signed [AW-1:0] bias_in;

    logic [1:0]           sum_ready_v;
    logic [1:0]           act_valid_v;
    logic [1:0]           act_last_v;
    logic [1:0]           layer_done_v;
    logic [1:0]           argmax_valid_v;
    logic signed [AW-1:0] act_out_v [2];
    logic [1:0]           argmax_idx_v [2];

    logic signed [SW-1:0] qsum;
    logic signed [AW-1:0] qbias;
    logic signed [AW-1:0] qact [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 is the ReLU instance, index 1 the linear one.
    int fill_v  [2][NN];
    int drain_v [2][NN];
    int fill_n;
    int rd_n;
    bit in_drain;
    bit exp_done;
    int exp_arg [2];

    int layer_a [NN] = '{10, 90, 90, 5};
    int layer_b [NN] = '{-40, -8, -100, -8};
    int bp_ready [4] = '{1, 0, 0, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        activation_buffer #(
            .NUM_NEURONS (NN),
            .SUM_WIDTH   (SW),
            .ACT_WIDTH   (AW),
            .FRAC_BITS   (5),
            .USE_RELU    ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .sum_valid    (sum_valid),
            .sum_ready    (sum_ready_v[g]),
            .sum_in       (sum_in),
            .bias_in      (bias_in),
            .act_valid    (act_valid_v[g]),
            .act_ready    (act_ready),
            .act_out      (act_out_v[g]),
            .act_last     (act_last_v[g]),
            .layer_done   (layer_done_v[g]),
            .argmax_idx   (argmax_idx_v[g]),
            .argmax_valid (argmax_valid_v[g])
        );

        act_quant #(
            .SUM_WIDTH (SW),
            .ACT_WIDTH (AW),
            .USE_RELU  ((g == 0) ? 1 : 0)
        ) u_quant (
            .sum_in  (qsum),
            .bias_in (qbias),
            .act_c   (qact[g])
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_act(input int s, input int b, input bit relu);
        int t;
        t = s + b;
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return t;
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(32'(hi - lo), 0));
    endfunction

    function automatic int first_max(input int r, input int n);
        int best;
        best = 0;
        for (int i = 1; i < n; i++) begin
            if (fill_v[r][i] > fill_v[r][best]) best = i;
        end
        return best;
    endfunction

    task automatic model_reset();
        fill_n   = 0;
        rd_n     = 0;
        in_drain = 1'b0;
        exp_done = 1'b0;
        exp_arg  = '{0, 0};
    endtask

    task automatic chk_outputs(input string ph);
        for (int r = 0; r < 2; r++) begin
            chk($sformatf("%s r%0d sum_ready", ph, r), int'(sum_ready_v[r]), int'(!in_drain));
            chk($sformatf("%s r%0d act_valid", ph, r), int'(act_valid_v[r]), int'(in_drain));
            chk($sformatf("%s r%0d argmax_valid", ph, r), int'(argmax_valid_v[r]), int'(in_drain));
            chk($sformatf("%s r%0d act_out", ph, r), int'(act_out_v[r]),
                in_drain ? drain_v[r][rd_n] : 0);
            chk($sformatf("%s r%0d act_last", ph, r), int'(act_last_v[r]),
                int'(in_drain && (rd_n == NN - 1)));
            chk($sformatf("%s r%0d layer_done", ph, r), int'(layer_done_v[r]), int'(exp_done));
            chk($sformatf("%s r%0d argmax_idx", ph, r), int'(argmax_idx_v[r]), exp_arg[r]);
        end
    endtask

    // One clock: drive, check the current cycle, advance, update the model.
    task automatic cyc(input string ph, input bit sv, input int s, input int b, input bit ar);
        sum_valid = sv;
        sum_in    = SW'(s);
        bias_in   = AW'(b);
        act_ready = ar;
        chk_outputs(ph);
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        if (!in_drain && sv) begin
            for (int r = 0; r < 2; r++) begin
                fill_v[r][fill_n] = ref_act(s, b, r == 0);
                exp_arg[r] = first_max(r, fill_n + 1);
            end
            fill_n++;
            if (fill_n == NN) begin
                drain_v  = fill_v;
                fill_n   = 0;
                rd_n     = 0;
                in_drain = 1'b1;
            end
        end else if (in_drain && ar) begin
            rd_n++;
            if (rd_n == NN) begin
                rd_n     = 0;
                in_drain = 1'b0;
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic qchk(input int s, input int b);
        qsum  = SW'(s);
        qbias = AW'(b);
        #1;
        for (int r = 0; r < 2; r++) begin
            chk($sformatf("quant r%0d s=%0d b=%0d", r, s, b), int'(qact[r]), ref_act(s, b, r == 0));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sum_valid = 1'b0;
        act_ready = 1'b0;
        sum_in    = '0;
        bias_in   = '0;
        qsum      = '0;
        qbias     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("rst_init");
        rst_n = 1'b1;

        // Quantizer corner cases with hand-computed results.
        qsum = SW'(100);  qbias = AW'(32); #1; chk("quant_sat_hi", int'(qact[0]), 127);
        qsum = SW'(-50);  qbias = AW'(10); #1; chk("quant_relu", int'(qact[0]), 0);
        qsum = SW'(40);   qbias = AW'(-8); #1; chk("quant_plain", int'(qact[0]), 32);
        qsum = SW'(-200); qbias = AW'(0);  #1; chk("quant_sat_lo", int'(qact[1]), -128);
        qsum = SW'(-1024); qbias = AW'(-128); #1; chk("quant_min", int'(qact[1]), -128);
        qsum = SW'(1023); qbias = AW'(127); #1; chk("quant_max", int'(qact[1]), 127);
        for (int i = 0; i < 40; i++) qchk(rnd(-1024, 1023), rnd(-128, 127));

        // Full layer with a tie, then a negative layer.
        for (int i = 0; i < NN; i++) cyc("layer_a", 1'b1, layer_a[i], 0, 1'b1);
        repeat (NN + 2) cyc("drain_a", 1'b0, 0, 0, 1'b1);
        chk("layer_a argmax relu", int'(argmax_idx_v[0]), 1);
        for (int i = 0; i < NN; i++) cyc("layer_b", 1'b1, layer_b[i], 0, 1'b1);
        chk("layer_b argmax linear", int'(argmax_idx_v[1]), 1);
        repeat (NN + 2) cyc("drain_b", 1'b0, 0, 0, 1'b1);

        // Backpressure; sum_valid stays high so ignored DRAIN sums are exercised.
        for (int i = 0; i < NN; i++) cyc("bp_fill", 1'b1, rnd(-300, 300), rnd(-128, 127), 1'b1);
        for (int i = 0; i < 16; i++)
            cyc("bp_drain", 1'b1, rnd(-300, 300), rnd(-128, 127), bp_ready[i % 4] != 0);
        repeat (2 * NN) cyc("bp_flush", 1'b0, 0, 0, 1'b1);

        // Back-to-back layers with no stalls.
        for (int i = 0; i < 6 * NN + 2; i++)
            cyc("b2b", 1'b1, rnd(-1024, 1023), rnd(-128, 127), 1'b1);
        repeat (2 * NN) cyc("b2b_flush", 1'b0, 0, 0, 1'b1);

        // Reset after a partial layer; only the fresh layer may come out.
        for (int i = 0; i < 2; i++) cyc("rst_part", 1'b1, rnd(-200, 200), 0, 1'b1);
        mid_reset();
        for (int i = 0; i < NN; i++) cyc("rst_new", 1'b1, rnd(-200, 200), rnd(-20, 20), 1'b1);
        repeat (NN + 2) cyc("rst_drain", 1'b0, 0, 0, 1'b1);

        // Random traffic, including a reset during DRAIN.
        for (int i = 0; i < 400; i++) begin
            cyc("rand", $urandom_range(9, 0) < 7, rnd(-1024, 1023), rnd(-128, 127),
                $urandom_range(9, 0) < 6);
            if (i == 200 && in_drain) mid_reset();
        end
        repeat (2 * NN + 2) cyc("final", 1'b0, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
